bram_infer: RTL and testbench

// - Inferable 16x8 block-RAM wrapper with one write/read port plus a look-ahead read port.
// - data_out_1 returns the word at addr; data_out_2 returns the word at addr+1 (wrapping), one clock later.
// - After reset, a built-in sequencer loads a known pattern (mem[i] = i) so readers see defined contents.
// - Serves as a small storage primitive for the LDPC decoder datapath.

---
 rtl/bram_pkg.sv | 14 +
 rtl/bram_infer_mem.sv | 55 +++++
 rtl/bram_infer.sv | 103 ++++++++++
 tb/tb_bram_infer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared defaults and FSM encoding for the 16x8 block-RAM wrapper.
// Imported by the top level and by the RAM sub-module.
package bram_pkg;

    localparam int BRAM_DATA_W = 8;
    localparam int BRAM_ADDR_W = 4;
    localparam int BRAM_DEPTH  = 1 << BRAM_ADDR_W;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } bram_state_e;

endpackage

// File: rtl/bram_infer_mem.sv
// Simple-dual-port RAM: port A write-first read/write, port B synchronous read.
// The array carries no reset so it maps onto block RAM; only the read registers clear.
module bram_infer_mem
    import bram_pkg::*;
#(
    parameter int DATA_W = BRAM_DATA_W,
    parameter int ADDR_W = BRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_clr,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Array write port, kept free of any reset so it stays inferable.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem_r[a_addr] <= a_wdata;
        end
    end

    // Port A read register: write-first, forced to zero while cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata <= {DATA_W{1'b0}};
        end else if (rd_clr) begin
            a_rdata <= {DATA_W{1'b0}};
        end else if (a_we) begin
            a_rdata <= a_wdata;
        end else begin
            a_rdata <= mem_r[a_addr];
        end
    end

    // Port B read register: always returns pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_rdata <= {DATA_W{1'b0}};
        end else if (rd_clr) begin
            b_rdata <= {DATA_W{1'b0}};
        end else begin
            b_rdata <= mem_r[b_addr];
        end
    end

endmodule

// File: rtl/bram_infer.sv
// Block-RAM wrapper with a look-ahead read port and a post-reset pattern loader.
// After reset the sequencer writes mem[i] = i, then user accesses are served.
module bram_infer
    import bram_pkg::*;
#(
    parameter int DATA_W = BRAM_DATA_W,
    parameter int ADDR_W = BRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              write,
    output logic [DATA_W-1:0] data_out_1,
    output logic [DATA_W-1:0] data_out_2
);

    localparam int DEPTH = 1 << ADDR_W;

    bram_state_e       state_r;
    bram_state_e       state_nxt_s;
    logic [ADDR_W-1:0] init_cnt_r;
    logic              init_last_s;
    logic              we_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              rd_clr_s;
    logic [ADDR_W-1:0] addr_inc_s;

    assign init_last_s = (init_cnt_r == ADDR_W'(DEPTH - 1));
    // Natural ADDR_W-bit overflow gives the DEPTH-1 -> 0 wrap.
    assign addr_inc_s  = addr + ADDR_W'(1);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pattern counter, advances only while loading.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_cnt_r <= {ADDR_W{1'b0}};
        end else if (state_r == ST_INIT) begin
            init_cnt_r <= init_cnt_r + ADDR_W'(1);
        end else begin
            init_cnt_r <= init_cnt_r;
        end
    end

    // Next state plus loader/user mux on the write port.
    always_comb begin
        state_nxt_s = state_r;
        we_s        = 1'b0;
        wr_addr_s   = addr;
        wr_data_s   = data_in;
        rd_clr_s    = 1'b1;
        case (state_r)
            ST_INIT: begin
                we_s      = 1'b1;
                wr_addr_s = init_cnt_r;
                wr_data_s = DATA_W'(init_cnt_r);
                rd_clr_s  = 1'b1;
                if (init_last_s) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_READY: begin
                we_s        = write;
                wr_addr_s   = addr;
                wr_data_s   = data_in;
                rd_clr_s    = 1'b0;
                state_nxt_s = ST_READY;
            end
            default: begin
                state_nxt_s = ST_INIT;
                we_s        = 1'b0;
                rd_clr_s    = 1'b1;
            end
        endcase
    end

    bram_infer_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (reset),
        .rd_clr  (rd_clr_s),
        .a_we    (we_s),
        .a_addr  (wr_addr_s),
        .a_wdata (wr_data_s),
        .a_rdata (data_out_1),
        .b_addr  (addr_inc_s),
        .b_rdata (data_out_2)
    );

endmodule

// File: tb/tb_bram_infer.sv
// Directed plus randomized bench for bram_infer against a behavioural memory model.
module tb_bram_infer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              write = 1'b0;
    logic [ADDR_W-1:0] addr = 4'h0;
    logic [DATA_W-1:0] data_in = 8'h00;
    logic [DATA_W-1:0] data_out_1;
    logic [DATA_W-1:0] data_out_2;

    int n_checks = 0;
    int n_fails  = 0;

    logic [DATA_W-1:0] model [DEPTH];
    int                init_left = DEPTH;
    logic [DATA_W-1:0] exp1 = 8'h00;
    logic [DATA_W-1:0] exp2 = 8'h00;

    always #5 clk = ~clk;

    bram_infer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .addr       (addr),
        .write      (write),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference behaviour of one rising edge, from the memory's externally visible rules.
    task automatic model_edge(input logic r, input logic w, input int a, input logic [DATA_W-1:0] d);
        if (!r) begin
            exp1      = 8'h00;
            exp2      = 8'h00;
            init_left = DEPTH;
        end else if (init_left > 0) begin
            model[DEPTH - init_left] = 8'(DEPTH - init_left);
            init_left--;
            exp1 = 8'h00;
            exp2 = 8'h00;
        end else begin
            exp1 = w ? d : model[a];
            exp2 = model[(a + 1) % DEPTH];
            if (w) model[a] = d;
        end
    endtask

    task automatic cycle(input logic r, input logic w, input int a, input logic [DATA_W-1:0] d, input string tag);
        @(negedge clk);
        reset   = r;
        write   = w;
        addr    = 4'(a);
        data_in = d;
        @(posedge clk);
        model_edge(r, w, a, d);
        #1;
        check({tag, "_o1"}, data_out_1, exp1);
        check({tag, "_o2"}, data_out_2, exp2);
    endtask

    initial begin
        for (int i = 0; i < 25; i++) cycle(1'b0, 1'b0, 0, 8'h00, "reset");

        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 0, 8'h00, "init");
        cycle(1'b1, 1'b0, 0, 8'h00, "first");
        check("first_c1", data_out_1, 8'h00);
        check("first_c2", data_out_2, 8'h01);

        for (int a = 1; a <= 3; a++) begin
            cycle(1'b1, 1'b0, a, 8'h00, "sweep");
            check("sweep_c1", data_out_1, 8'(a));
            check("sweep_c2", data_out_2, 8'(a + 1));
            cycle(1'b1, 1'b0, a, 8'h00, "hold");
            cycle(1'b1, 1'b0, a, 8'h00, "hold");
        end

        cycle(1'b1, 1'b0, 15, 8'h00, "wrap");
        check("wrap_c1", data_out_1, 8'h0F);
        check("wrap_c2", data_out_2, 8'h00);

        cycle(1'b1, 1'b1, 5, 8'hA5, "wrfirst");
        check("wrfirst_c1", data_out_1, 8'hA5);
        cycle(1'b1, 1'b0, 4, 8'h00, "lookahead");
        check("lookahead_c2", data_out_2, 8'hA5);
        cycle(1'b1, 1'b0, 5, 8'h00, "readback");
        check("readback_c1", data_out_1, 8'hA5);
        check("readback_c2", data_out_2, 8'h06);

        // Asynchronous clear is visible before the next clock edge.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_c1", data_out_1, 8'h00);
        check("async_c2", data_out_2, 8'h00);
        cycle(1'b0, 1'b0, 5, 8'h00, "midrst");
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 5, 8'h00, "reinit");
        cycle(1'b1, 1'b0, 5, 8'h00, "restored");
        check("restored_c1", data_out_1, 8'h05);

        cycle(1'b0, 1'b0, 0, 8'h00, "rst2");
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, int'($urandom_range(0, 15)), 8'hFF, "initwr");
        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b1, 1'b0, a, 8'h00, "pattern");
            check("pattern_c1", data_out_1, 8'(a));
        end

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 15)), 8'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
